// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter and pointer/occupancy control for the shared FIFO
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_WIDTH = 16,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          rd_en,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         wr_data,
    output logic [PTR_WIDTH:0]            b_wptr,
    output logic [PTR_WIDTH:0]            b_rptr,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [PTR_WIDTH:0]            count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = PTR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [IDX_W-1:0] prio_q, prio_d;
    logic [CNT_W-1:0] b_wptr_q, b_wptr_d;
    logic [CNT_W-1:0] b_rptr_q, b_rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_full_q, fifo_full_d;
    logic             fifo_empty_q, fifo_empty_d;

    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic             wr_acc;
    logic             rd_acc;

    // Round-robin scan starting at prio; full or reset suppresses any grant.
    always_comb begin
        int cand;
        cand    = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            cand = int'(prio_q) + o;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!gnt_vld && req[IDX_W'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
        if (rst || fifo_full_q) begin
            gnt_vld = 1'b0;
        end
    end

    // Grant vector and the write-data mux of the winning producer.
    always_comb begin
        gnt     = '0;
        wr_data = '0;
        if (gnt_vld) begin
            gnt     = NUM_REQ'(1) << gnt_idx;
            wr_data = req_data[int'(gnt_idx)*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    assign wr_en  = gnt_vld;
    assign wr_acc = gnt_vld;
    assign rd_acc = rd_en & ~fifo_empty_q;

    // Next-state for priority, pointers, occupancy and flags.
    always_comb begin
        int nxt;
        nxt      = 0;
        prio_d   = prio_q;
        b_wptr_d = b_wptr_q;
        b_rptr_d = b_rptr_q;
        count_d  = count_q;
        if (gnt_vld) begin
            nxt = int'(gnt_idx) + 1;
            if (nxt >= NUM_REQ) begin
                nxt = 0;
            end
            prio_d = IDX_W'(nxt);
        end
        if (wr_acc) begin
            b_wptr_d = b_wptr_q + 1'b1;
        end
        if (rd_acc) begin
            b_rptr_d = b_rptr_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        fifo_full_d  = (count_d == DEPTH_C);
        fifo_empty_d = (count_d == '0);
    end

    // State registers; reset drops contents and blocks any access on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q       <= '0;
            b_wptr_q     <= '0;
            b_rptr_q     <= '0;
            count_q      <= '0;
            fifo_full_q  <= 1'b0;
            fifo_empty_q <= 1'b1;
        end else begin
            prio_q       <= prio_d;
            b_wptr_q     <= b_wptr_d;
            b_rptr_q     <= b_rptr_d;
            count_q      <= count_d;
            fifo_full_q  <= fifo_full_d;
            fifo_empty_q <= fifo_empty_d;
        end
    end

    assign b_wptr     = b_wptr_q;
    assign b_rptr     = b_rptr_q;
    assign count      = count_q;
    assign fifo_full  = fifo_full_q;
    assign fifo_empty = fifo_empty_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  b_wptr;
    logic [3:0]  b_rptr;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  count;

    int n_tests;
    int n_fail;

    fifo_wr_arbiter #(
        .NUM_REQ(4), .FIFO_DEPTH(8), .FIFO_WIDTH(16), .PTR_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data), .b_wptr(b_wptr),
        .b_rptr(b_rptr), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pdata(input int i);
        logic [63:0] d;
        d = 64'hD3D3_C2C2_B1B1_A0A0;
        return d[i*16 +: 16];
    endfunction

    // Apply inputs (at negedge), check grant side combinationally, then advance one edge.
    task automatic step(input logic [3:0] r, input logic rd, input logic rs,
                        input logic [3:0] exp_gnt, input string tag);
        int gi;
        req   = r;
        rd_en = rd;
        rst   = rs;
        #1;
        gi = 0;
        for (int i = 0; i < 4; i++) if (exp_gnt[i]) gi = i;
        check_val({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check_val({tag, "_wr_en"}, 32'(wr_en), 32'(exp_gnt != 4'b0));
        check_val({tag, "_wr_data"}, 32'(wr_data), (exp_gnt != 4'b0) ? 32'(pdata(gi)) : 32'h0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [3:0] wp, input logic [3:0] rp,
                               input logic [3:0] cnt, input logic full, input logic empty);
        check_val({tag, "_wptr"}, 32'(b_wptr), 32'(wp));
        check_val({tag, "_rptr"}, 32'(b_rptr), 32'(rp));
        check_val({tag, "_count"}, 32'(count), 32'(cnt));
        check_val({tag, "_full"}, 32'(fifo_full), 32'(full));
        check_val({tag, "_empty"}, 32'(fifo_empty), 32'(empty));
    endtask

    initial begin
        logic [3:0] seq [4];
        n_tests  = 0;
        n_fail   = 0;
        req_data = 64'hD3D3_C2C2_B1B1_A0A0;
        req      = 4'b1111;
        rd_en    = 1'b0;
        rst      = 1'b1;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
        @(negedge clk);

        // Reset held two cycles with all requests high.
        step(4'b1111, 1'b0, 1'b1, 4'b0000, "rst1");
        step(4'b1111, 1'b0, 1'b1, 4'b0000, "rst2");
        check_state("rst", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);

        // Round-robin with continuous reads: first write lands in empty FIFO.
        for (int c = 0; c < 8; c++) begin
            step(4'b1111, 1'b1, 1'b0, seq[c % 4], $sformatf("rr%0d", c));
            check_val($sformatf("rr%0d_count", c), 32'(count), 32'd1);
        end
        check_state("rr_end", 4'd8, 4'd7, 4'd1, 1'b0, 1'b0);

        // Sparse: move prio to 2, then req=0011 grants 0 then 1.
        step(4'b0010, 1'b0, 1'b0, 4'b0010, "sp_setup");
        step(4'b0011, 1'b0, 1'b0, 4'b0001, "sp_a");
        step(4'b0011, 1'b0, 1'b0, 4'b0010, "sp_b");
        check_state("sp_end", 4'd11, 4'd7, 4'd4, 1'b0, 1'b0);

        // Drain, then a read while empty leaves b_rptr alone.
        for (int c = 0; c < 4; c++) step(4'b0000, 1'b1, 1'b0, 4'b0000, $sformatf("dr%0d", c));
        check_state("drained", 4'd11, 4'd11, 4'd0, 1'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b0, 4'b0000, "empty_rd");
        check_state("empty_rd", 4'd11, 4'd11, 4'd0, 1'b0, 1'b1);

        // Five writes, then reset with req and rd_en active.
        for (int c = 0; c < 5; c++) step(4'b0001, 1'b0, 1'b0, 4'b0001, $sformatf("pre%0d", c));
        check_state("pre5", 4'd0, 4'd11, 4'd5, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b1, 4'b0000, "midrst");
        check_state("midrst", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);

        // Fill to full from a clean state.
        for (int c = 0; c < 8; c++) begin
            step(4'b0001, 1'b0, 1'b0, 4'b0001, $sformatf("fill%0d", c));
            check_val($sformatf("fill%0d_count", c), 32'(count), 32'(c + 1));
        end
        check_state("full", 4'd8, 4'd0, 4'd8, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 4'b0000, "full_blk1");
        step(4'b0001, 1'b0, 1'b0, 4'b0000, "full_blk2");
        check_state("full_hold", 4'd8, 4'd0, 4'd8, 1'b1, 1'b0);

        // Read at full: write blocked this cycle, granted the next.
        step(4'b0001, 1'b1, 1'b0, 4'b0000, "full_rd");
        check_state("full_rd", 4'd8, 4'd1, 4'd7, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 4'b0001, "refill");
        check_state("refill", 4'd9, 4'd1, 4'd8, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Single-clock write-side controller for the shared FIFO memory.
- Arbitrates NUM_REQ producers onto the one memory write port using round-robin.
- Owns the binary write/read pointers, occupancy count and full/empty flags.
- Drives the memory's write enable, write data and pointer inputs; the downstream consumer supplies rd_en.

Parameters:
- NUM_REQ, 4, number of requesting producers (2..8).
- FIFO_DEPTH, 8, memory entries; must equal 2**PTR_WIDTH.
- FIFO_WIDTH, 16, data word width.
- PTR_WIDTH, 3, address bits; pointers are PTR_WIDTH+1 bits (MSB is the wrap bit).

Ports:
- clk  in  1  single system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-producer write request; bit i belongs to producer i.
- req_data  in  NUM_REQ*FIFO_WIDTH  producer i data occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- gnt  out  NUM_REQ  one-hot grant, combinational; the word is accepted in any cycle where gnt[i]=1.
- rd_en  in  1  consumer read request.
- wr_en  out  1  memory write enable, equal to |gnt.
- wr_data  out  FIFO_WIDTH  req_data slice of the granted producer; 0 when there is no grant.
- b_wptr  out  PTR_WIDTH+1  binary write pointer; memory address = b_wptr[PTR_WIDTH-1:0].
- b_rptr  out  PTR_WIDTH+1  binary read pointer.
- fifo_full  out  1  registered; count == FIFO_DEPTH.
- fifo_empty  out  1  registered; count == 0.
- count  out  PTR_WIDTH+1  registered occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - b_wptr=0, b_rptr=0, count=0, fifo_empty=1, fifo_full=0, priority pointer prio=0.
  - While rst=1, gnt=0, wr_en=0 and wr_data=0 regardless of req.
  - Reset asserted mid-operation discards all contents in that cycle; no write or read is accepted on the reset edge.
- Arbitration (combinational, from registered prio and fifo_full):
  - If fifo_full=1 or req=0: gnt=0.
  - Otherwise grant the first asserted req at or after index prio, scanning upward modulo NUM_REQ.
  - Exactly one grant per cycle at most.
- Priority update (posedge):
  - On any grant to index k: prio <= (k+1) mod NUM_REQ.
  - With no grant, prio holds.
  - Guarantees each continuously requesting producer a grant within NUM_REQ accepted writes.
- Producer rule: req and its data are held stable until gnt; req may deassert without a grant (request withdrawn, nothing written).
- Write accepted = wr_en. On accept, b_wptr <= b_wptr+1; wraps naturally through 2*FIFO_DEPTH, and the MSB toggles every FIFO_DEPTH writes.
- Read accepted = rd_en & ~fifo_empty. On accept, b_rptr <= b_rptr+1. rd_en while empty is ignored, with no pointer change.
- Count:
  - write only: +1.
  - read only: -1.
  - both or neither: unchanged.
- Flags: fifo_full and fifo_empty are registered from the next-state count in the same edge, so they are valid in the cycle after the changing access.
- Simultaneous events:
  - Full with rd_en: the read is accepted; the write is blocked that cycle (full is registered); the next cycle is not full and a write may be granted.
  - Empty with a write and rd_en: the read is ignored and the write is accepted; count becomes 1.
  - Not full and not empty with both: both are accepted; count holds and both pointers advance.
- Invariant: count == b_wptr - b_rptr (mod 2*FIFO_DEPTH). fifo_full and fifo_empty are never both 1.

Test Plan:
- Reset/idle: assert rst 2 cycles with req=4'b1111 → gnt=0, wr_en=0, count=0, fifo_empty=1, pointers 0. After release, the first cycle grants gnt=4'b0001.
- Round-robin fairness: all four req high with rd_en=1 continuously for 8 cycles → gnt sequence 0001,0010,0100,1000 repeating; each producer gets 2 writes; count stays ≤1.
- Sparse requests: prio=2, req=4'b0011 → gnt=4'b0001; the next cycle with req=4'b0011 gives gnt=4'b0010.
- Fill to full: req[0] high, rd_en=0 → exactly 8 writes, b_wptr=8 (4'b1000), fifo_full=1 after the 8th, and gnt=0 afterwards while req stays high.
- Full plus read: at full, rd_en=1 for one cycle → b_rptr=1, count=7, fifo_full=0 the next cycle; the write is granted in that next cycle and count returns to 8.
- Empty read and mid-operation reset: rd_en=1 while empty → b_rptr unchanged. At count=5, assert rst with req and rd_en active → next cycle count=0, pointers 0, no write on the reset edge.
